// File: rtl/jam_pkg.sv
// Shared types and sizing for the jam_sched assignment-search block.
// N_WORK is fixed at 8, so worker and job indices are always 3 bits.
package jam_pkg;

  localparam int N_WORK = 8;
  localparam int COST_W = 7;
  localparam int SUM_W  = 10;
  localparam int CNT_W  = 16;

  localparam logic [SUM_W-1:0] MIN_RST = '1;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    FETCH,
    DRAIN,
    CMP,
    DONE
  } state_t;

endpackage

// File: rtl/jam_sched_if.sv
// Permutation stream into jam_sched: valid/ready, with perm_last qualifying the final permutation.
// Master is the permutation generator; the scheduler drives perm_ready only while it is waiting for a permutation.
interface jam_sched_if;
  import jam_pkg::*;

  logic                  perm_valid;
  logic [3*N_WORK-1:0]   perm_job;
  logic                  perm_last;
  logic                  perm_ready;

  modport master (output perm_valid, perm_job, perm_last, input perm_ready);
  modport slave  (input perm_valid, perm_job, perm_last, output perm_ready);

endinterface

// File: rtl/jam_acc.sv
// Sums one permutation's costs and folds the total into MinCost/MatchCount; all updates take effect the cycle after the strobe.
// Never stalls: it follows the strobes from jam_sched, and MatchCount stops at all-ones instead of wrapping.
module jam_acc #(
  parameter int COST_W = jam_pkg::COST_W,
  parameter int SUM_W  = jam_pkg::SUM_W,
  parameter int CNT_W  = jam_pkg::CNT_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_init,
  input  logic              i_clr,
  input  logic              i_add,
  input  logic [COST_W-1:0] i_cost,
  input  logic              i_cmp,
  output logic [SUM_W-1:0]  o_min_cost,
  output logic [CNT_W-1:0]  o_match_cnt,
  output logic              o_over
);

  logic [SUM_W-1:0] r_acc;
  logic [SUM_W-1:0] r_min;
  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_acc <= '0;
      r_min <= '1;
      r_cnt <= '0;
    end else begin
      if (i_clr) begin
        r_acc <= '0;
      end else if (i_add) begin
        r_acc <= r_acc + SUM_W'(i_cost);
      end

      if (i_init) begin
        r_min <= '1;
        r_cnt <= '0;
      end else if (i_cmp) begin
        if (r_acc < r_min) begin
          r_min <= r_acc;
          r_cnt <= CNT_W'(1);
        end else if ((r_acc == r_min) && (r_cnt != '1)) begin
          r_cnt <= r_cnt + CNT_W'(1);
        end
      end
    end
  end

  assign o_min_cost  = r_min;
  assign o_match_cnt = r_cnt;
  assign o_over      = (r_acc > r_min);

endmodule

// File: rtl/jam_sched.sv
// Brute-force assignment search: each permutation costs LOAD 1 + FETCH 8 + DRAIN 1 + CMP 1 = 11 cycles; LOAD waits on perm_valid.
// JAM_PRUNE_EN: a permutation is abandoned as soon as its partial sum exceeds MinCost.
module jam_sched #(
  parameter int N_WORK = jam_pkg::N_WORK,
  parameter int COST_W = jam_pkg::COST_W,
  parameter int SUM_W  = jam_pkg::SUM_W,
  parameter int CNT_W  = jam_pkg::CNT_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  jam_sched_if.slave        perm_if,
  output logic [2:0]        W,
  output logic [2:0]        J,
  input  logic [COST_W-1:0] Cost,
  output logic [SUM_W-1:0]  MinCost,
  output logic [CNT_W-1:0]  MatchCount,
  output logic              Valid
);
  import jam_pkg::*;

`ifdef JAM_PRUNE_EN
  localparam bit PRUNE = 1'b1;
`else
  localparam bit PRUNE = 1'b0;
`endif

  state_t              r_state;
  logic [2:0]          r_w;
  logic [2:0]          r_j;
  logic [3*N_WORK-1:0] r_job;
  logic                r_last;
  logic                r_ready;
  logic                r_valid;

  logic [2:0] w_next;
  logic       w_last_addr;
  logic       w_xfer;
  logic       w_init;
  logic       w_add;
  logic       w_cmp;
  logic       w_over;
  logic       w_prune;

  assign w_next      = r_w + 3'd1;
  assign w_last_addr = (r_w == 3'(N_WORK - 1));
  assign w_xfer      = r_ready && perm_if.perm_valid;
  assign w_init      = (r_state == IDLE) && start;
  // Cost lags its address by a cycle, so FETCH adds from the second address on and DRAIN adds the last one.
  assign w_add       = ((r_state == FETCH) && (r_w != 3'd0)) || (r_state == DRAIN);
  assign w_cmp       = (r_state == CMP);
  assign w_prune     = PRUNE && w_over && ((r_state == FETCH) || (r_state == DRAIN));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
      r_w     <= '0;
      r_j     <= '0;
      r_job   <= '0;
      r_last  <= 1'b0;
      r_ready <= 1'b0;
      r_valid <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_state <= LOAD;
            r_ready <= 1'b1;
          end
        end
        LOAD: begin
          if (w_xfer) begin
            r_job   <= perm_if.perm_job;
            r_last  <= perm_if.perm_last;
            r_ready <= 1'b0;
            r_w     <= '0;
            r_j     <= perm_if.perm_job[2:0];
            r_state <= FETCH;
          end
        end
        FETCH: begin
          if (w_prune) begin
            r_w     <= '0;
            r_j     <= '0;
            r_state <= r_last ? DONE : LOAD;
            r_valid <= r_last;
            r_ready <= !r_last;
          end else if (w_last_addr) begin
            r_w     <= '0;
            r_j     <= '0;
            r_state <= DRAIN;
          end else begin
            r_w <= w_next;
            r_j <= r_job[3*int'(w_next) +: 3];
          end
        end
        DRAIN: begin
          if (w_prune) begin
            r_state <= r_last ? DONE : LOAD;
            r_valid <= r_last;
            r_ready <= !r_last;
          end else begin
            r_state <= CMP;
          end
        end
        CMP: begin
          r_state <= r_last ? DONE : LOAD;
          r_valid <= r_last;
          r_ready <= !r_last;
        end
        DONE: begin
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign W                  = r_w;
  assign J                  = r_j;
  assign Valid              = r_valid;
  assign perm_if.perm_ready = r_ready;

  jam_acc #(
    .COST_W (COST_W),
    .SUM_W  (SUM_W),
    .CNT_W  (CNT_W)
  ) u_acc (
    .clk         (clk),
    .rst         (rst),
    .i_init      (w_init),
    .i_clr       (w_xfer),
    .i_add       (w_add),
    .i_cost      (Cost),
    .i_cmp       (w_cmp),
    .o_min_cost  (MinCost),
    .o_match_cnt (MatchCount),
    .o_over      (w_over)
  );

endmodule

// File: tb/tb_jam_sched.sv
// Random permutation streams and cost tables driven into jam_sched, compared against a behavioural search model.
module tb_jam_sched;

  logic        clk;
  logic        rst;
  logic        start;
  logic [2:0]  W;
  logic [2:0]  J;
  logic [6:0]  Cost;
  logic [9:0]  MinCost;
  logic [15:0] MatchCount;
  logic        Valid;

  jam_sched_if pif ();

  jam_sched dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .perm_if    (pif),
    .W          (W),
    .J          (J),
    .Cost       (Cost),
    .MinCost    (MinCost),
    .MatchCount (MatchCount),
    .Valid      (Valid)
  );

  int          n_chk = 0;
  int          n_bad = 0;
  logic [6:0]  tbl [64];
  logic [23:0] perms [$];

  always #5 clk = ~clk;

  // Cost table with one cycle of read latency.
  always @(posedge clk) Cost <= tbl[{W, J}];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // mode 0: identity table, 1: every entry v, 2: random 0..v
  task automatic set_tbl(input int mode, input int v);
    for (int w = 0; w < 8; w++)
      for (int j = 0; j < 8; j++)
        case (mode)
          0:       tbl[w*8+j] = (w == j) ? 7'd1 : 7'd10;
          1:       tbl[w*8+j] = 7'(v);
          default: tbl[w*8+j] = 7'($urandom_range(v, 0));
        endcase
  endtask

  task automatic gen_perms(input int k, input bit ident);
    logic [2:0]  a [8];
    logic [2:0]  t;
    logic [23:0] p;
    int          r;
    perms.delete();
    for (int i = 0; i < k; i++) begin
      for (int w = 0; w < 8; w++) a[w] = 3'(w);
      for (int j = 7; j > 0; j--) begin
        r = $urandom_range(j, 0);
        t = a[j]; a[j] = a[r]; a[r] = t;
      end
      for (int w = 0; w < 8; w++) p[3*w +: 3] = a[w];
      perms.push_back(p);
    end
    if (ident) begin
      for (int w = 0; w < 8; w++) p[3*w +: 3] = 3'(w);
      perms[$urandom_range(k-1, 0)] = p;
    end
  endtask

  // Search result plus cycles from the start edge to the Valid cycle.
  task automatic model(input int stall, output int emin, output int ecnt, output int elat, output int npr);
    int m, cnt, lat, body, acc, tot;
    int e [8];
    bit pr;
    m = 1023; cnt = 0; lat = 0; npr = 0;
    foreach (perms[i]) begin
      tot = 0;
      for (int w = 0; w < 8; w++) begin
        e[w] = int'(tbl[w*8 + int'(perms[i][3*w +: 3])]);
        tot += e[w];
      end
      body = 10;
      pr = 1'b0;
      acc = 0;
`ifdef JAM_PRUNE_EN
      // During address slot k the running sum holds the costs of the first k-1 addresses.
      for (int k = 0; k <= 8; k++) begin
        if (k >= 2) acc += e[k-2];
        if (acc > m) begin
          body = k + 1;
          pr = 1'b1;
          break;
        end
      end
`endif
      if (pr) begin
        npr++;
      end else if (tot < m) begin
        m = tot; cnt = 1;
      end else if (tot == m && cnt < 65535) begin
        cnt++;
      end
      lat += 1 + stall + body;
    end
    emin = m; ecnt = cnt; elat = lat + 1;
  endtask

  task automatic run(input string nm, input int stall, input bit glitch, input int abort_at);
    int k, idx, stl, vcnt, lat, wjbad, abort_c, emin, ecnt, elat, npr, budget;
    bit pend, done, aborted;
    logic [9:0]  minv;
    logic [15:0] cntv;
    k = perms.size();
    model(stall, emin, ecnt, elat, npr);
    idx = 0; stl = stall; vcnt = 0; lat = 0; wjbad = 0; abort_c = -1;
    pend = 0; done = 0; aborted = 0; minv = '0; cntv = '0;
    budget = k * (11 + stall) + 40;
    @(negedge clk);
    start = 1'b1;
    pif.perm_job   = perms[0];
    pif.perm_last  = (k == 1);
    pif.perm_valid = (stl == 0);
    for (int c = 1; c <= budget && !done; c++) begin
      @(negedge clk);
      start = glitch && (c == 5);
      if (pend) begin
        idx++;
        stl  = stall;
        pend = 0;
        if (abort_at >= 0 && idx == abort_at + 1) abort_c = c + 2;
      end
      if (Valid) begin
        vcnt++;
        if (vcnt == 1) begin
          lat = c; minv = MinCost; cntv = MatchCount;
        end
      end
      if (pif.perm_ready && (W != 3'd0 || J != 3'd0)) wjbad++;
      pif.perm_valid = (idx < k) && (stl == 0);
      if (idx < k) begin
        pif.perm_job  = perms[idx];
        pif.perm_last = (idx == k - 1);
      end
      if (pif.perm_ready && !pif.perm_valid && stl > 0) stl--;
      pend = pif.perm_valid && pif.perm_ready;
      if (vcnt > 0 && c >= lat + 3) done = 1;
      if (c == abort_c) begin
        start = 1'b0;
        pif.perm_valid = 1'b0;
        rst = 1'b0;
        #1;
        chk({nm, "_rst_min"}, MinCost, 1023);
        chk({nm, "_rst_cnt"}, MatchCount, 0);
        chk({nm, "_rst_valid"}, Valid, 0);
        chk({nm, "_rst_ready"}, pif.perm_ready, 0);
        chk({nm, "_rst_w"}, W, 0);
        chk({nm, "_rst_j"}, J, 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        aborted = 1;
        done = 1;
      end
    end
    pif.perm_valid = 1'b0;
    start = 1'b0;
    if (abort_at >= 0) chk({nm, "_aborted"}, aborted, 1);
    if (aborted) begin
      chk({nm, "_valid_pulses"}, vcnt, 0);
    end else begin
      chk({nm, "_valid_pulses"}, vcnt, 1);
      chk({nm, "_min"}, minv, emin);
      chk({nm, "_count"}, cntv, ecnt);
      chk({nm, "_min_hold"}, MinCost, emin);
      chk({nm, "_count_hold"}, MatchCount, ecnt);
      chk({nm, "_latency"}, lat, elat);
      chk({nm, "_load_wj_zero"}, wjbad, 0);
`ifdef JAM_PRUNE_EN
      if (npr > 0) chk({nm, "_pruned_faster"}, lat < k * (11 + stall) + 1, 1);
`endif
    end
  endtask

  initial begin
    clk = 1'b0;
    rst = 1'b1;
    start = 1'b0;
    pif.perm_valid = 1'b0;
    pif.perm_job   = '0;
    pif.perm_last  = 1'b0;
    set_tbl(2, 127);
    #1 rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_min", MinCost, 1023);
    chk("reset_count", MatchCount, 0);
    chk("reset_valid", Valid, 0);
    chk("reset_ready", pif.perm_ready, 0);
    chk("reset_w", W, 0);
    chk("reset_j", J, 0);
    rst = 1'b1;
    @(negedge clk);

    set_tbl(0, 0);   gen_perms(200, 1); run("ident", 0, 0, -1);
    chk("ident_min_is_8", MinCost, 8);
    set_tbl(1, 5);   gen_perms(300, 0); run("equal", 0, 0, -1);
    chk("equal_min_is_40", MinCost, 40);
    set_tbl(2, 127); gen_perms(150, 0); run("rand", 0, 0, -1);
    run("stall", 5, 0, -1);
    set_tbl(2, 3);   gen_perms(150, 0); run("ties_start_glitch", 0, 1, -1);
    set_tbl(1, 127); gen_perms(20, 0);  run("max_cost", 0, 0, -1);
    set_tbl(2, 127); gen_perms(1, 0);   run("single", 0, 0, -1);
    set_tbl(2, 60);  gen_perms(150, 0); run("abort", 0, 0, 100);
    run("rerun", 0, 0, -1);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
